// File: rtl/ship_bullet_ctrl_pkg.sv
// rtl/ship_bullet_ctrl_pkg.sv - shared types and constants for the ship/bullet controller
// Purpose: heading enum, HID keycodes, screen limits, bullet slot record and a
//          modulo step helper used by the background scroll.
// Ports:   none (package).
package bosconian_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } heading_t;

  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_FIRE  = 8'h2C;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int LIFE_W   = 8;

  typedef struct packed {
    logic              active;
    logic [9:0]        x;
    logic [9:0]        y;
    heading_t          dir;
    logic [LIFE_W-1:0] life;
  } bullet_t;

  // One scroll step of 'step' pixels, wrapping modulo 'limit' in either direction.
  function automatic logic [9:0] wrap_step(input logic [9:0] pos, input logic [9:0] step,
                                           input logic up, input logic [10:0] limit);
    logic [10:0] r;
    if (up) begin
      r = {1'b0, pos} + {1'b0, step};
      if (r >= limit) r = r - limit;
    end else if (pos < step) begin
      r = {1'b0, pos} + limit - {1'b0, step};
    end else begin
      r = {1'b0, pos} - {1'b0, step};
    end
    return r[9:0];
  endfunction

endpackage

// File: rtl/ship_bullet_ctrl_if.sv
// rtl/ship_bullet_ctrl_if.sv - signal bundle between the controller and its neighbours
// Purpose: groups keyboard/frame/raster inputs and ship/bullet outputs.
// Ports:   master drives keycode, frame_tick, DrawX, DrawY and observes the
//          controller outputs; slave is the controller side.
interface ship_bullet_ctrl_if;
  import bosconian_pkg::*;

  logic [7:0] keycode;
  logic       frame_tick;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  heading_t   heading;
  logic       moving;
  logic [9:0] scroll_x;
  logic [9:0] scroll_y;
  logic       shoot_bullet;
  logic       bullet_on;
  logic       fire_ack;

  modport master (
    output keycode, frame_tick, DrawX, DrawY,
    input  heading, moving, scroll_x, scroll_y, shoot_bullet, bullet_on, fire_ack
  );

  modport slave (
    input  keycode, frame_tick, DrawX, DrawY,
    output heading, moving, scroll_x, scroll_y, shoot_bullet, bullet_on, fire_ack
  );

endinterface

// File: rtl/ship_bullet_ctrl_bullet_slot.sv
// rtl/ship_bullet_ctrl_bullet_slot.sv - one bullet: launch, per-frame motion, expiry, pixel hit
// Purpose: holds a single bullet_t; IDLE->ACTIVE on launch, ACTIVE->IDLE on
//          life expiry or leaving the screen.
// Ports:   sys_clk, reset_n (sync, active-low); launch_i, frame_tick_i,
//          launch_dir_i; draw_x_i/draw_y_i raster query; active_o, free_o
//          (idle now or retiring on this tick), hit_o (combinational pixel hit).
module bullet_slot
  import bosconian_pkg::*;
#(
  parameter int BULLET_SPEED = 4,
  parameter int BULLET_LIFE  = 64,
  parameter int BULLET_HALF  = 1,
  parameter int SHIP_X       = 320,
  parameter int SHIP_Y       = 240
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       launch_i,
  input  logic       frame_tick_i,
  input  heading_t   launch_dir_i,
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  output logic       active_o,
  output logic       free_o,
  output logic       hit_o
);

  localparam logic signed [10:0] SPD   = 11'(BULLET_SPEED);
  localparam logic signed [10:0] HALF  = 11'(BULLET_HALF);
  localparam logic signed [10:0] LIM_X = 11'(SCREEN_W);
  localparam logic signed [10:0] LIM_Y = 11'(SCREEN_H);

  bullet_t            slot_q, slot_d;
  logic signed [10:0] nx, ny, dx, dy;
  logic [LIFE_W-1:0]  life_dec;
  logic               retire;

  always_ff @(posedge sys_clk) begin
    if (!reset_n) slot_q <= '0;
    else          slot_q <= slot_d;
  end

  always_comb begin
    nx = $signed({1'b0, slot_q.x});
    ny = $signed({1'b0, slot_q.y});
    case (slot_q.dir)
      UP:    ny = ny - SPD;
      DOWN:  ny = ny + SPD;
      LEFT:  nx = nx - SPD;
      RIGHT: nx = nx + SPD;
    endcase
    life_dec = slot_q.life - 1'b1;
    // Signed compare so a step past 0 reads as negative instead of wrapping.
    retire = slot_q.active && frame_tick_i &&
             ((life_dec == '0) || (nx < 0) || (nx >= LIM_X) || (ny < 0) || (ny >= LIM_Y));

    slot_d = slot_q;
    if (launch_i) begin
      slot_d.active = 1'b1;
      slot_d.x      = 10'(SHIP_X);
      slot_d.y      = 10'(SHIP_Y);
      slot_d.dir    = launch_dir_i;
      slot_d.life   = LIFE_W'(BULLET_LIFE);
    end else if (retire) begin
      slot_d.active = 1'b0;
    end else if (slot_q.active && frame_tick_i) begin
      slot_d.x    = nx[9:0];
      slot_d.y    = ny[9:0];
      slot_d.life = life_dec;
    end
  end

  always_comb begin
    dx    = $signed({1'b0, draw_x_i}) - $signed({1'b0, slot_q.x});
    dy    = $signed({1'b0, draw_y_i}) - $signed({1'b0, slot_q.y});
    hit_o = slot_q.active && (dx >= -HALF) && (dx <= HALF) && (dy >= -HALF) && (dy <= HALF);
  end

  assign active_o = slot_q.active;
  // A slot retiring on this tick may be reloaded on the same tick.
  assign free_o   = !slot_q.active || retire;

endmodule

// File: rtl/ship_bullet_ctrl.sv
// rtl/ship_bullet_ctrl.sv - keyboard to ship heading, background scroll and bullet pool
// Purpose: key decode, fire edge/cooldown, scroll offsets, free-slot priority
//          launch, and OR-reduction of slot activity and pixel hits.
// Ports:   sys_clk, reset_n (sync, active-low); bus (slave): keycode,
//          frame_tick, DrawX, DrawY in; heading, moving, scroll_x, scroll_y,
//          shoot_bullet, bullet_on, fire_ack out.
module ship_bullet_ctrl
  import bosconian_pkg::*;
#(
  parameter int NUM_BULLETS   = 4,
  parameter int BULLET_SPEED  = 4,
  parameter int BULLET_LIFE   = 64,
  parameter int FIRE_COOLDOWN = 8,
  parameter int SCROLL_SPEED  = 1,
  parameter int BULLET_HALF   = 1,
  parameter int SHIP_X        = 320,
  parameter int SHIP_Y        = 240
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  ship_bullet_ctrl_if.slave bus
);

  localparam logic [9:0] SCROLL_STEP = 10'(SCROLL_SPEED);

  heading_t         heading_q, heading_d;
  logic             moving_q, moving_d;
  logic             fire_prev_q, fire_pending_q, fire_pending_d;
  logic             fire_held, fire_edge;
  logic [7:0]       cooldown_q, cooldown_d;
  logic [9:0]       scroll_x_q, scroll_x_d, scroll_y_q, scroll_y_d;
  logic             shoot_q, bullet_on_q;
  logic             launch_ok, found;
  logic [NUM_BULLETS-1:0] slot_active, slot_free, slot_hit, launch_vec;

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      heading_q      <= UP;
      moving_q       <= 1'b0;
      fire_prev_q    <= 1'b0;
      fire_pending_q <= 1'b0;
      cooldown_q     <= '0;
      scroll_x_q     <= '0;
      scroll_y_q     <= '0;
      shoot_q        <= 1'b0;
      bullet_on_q    <= 1'b0;
    end else begin
      heading_q      <= heading_d;
      moving_q       <= moving_d;
      fire_prev_q    <= fire_held;
      fire_pending_q <= fire_pending_d;
      cooldown_q     <= cooldown_d;
      scroll_x_q     <= scroll_x_d;
      scroll_y_q     <= scroll_y_d;
      shoot_q        <= |slot_active;
      bullet_on_q    <= |slot_hit;
    end
  end

  always_comb begin
    heading_d = heading_q;
    moving_d  = 1'b0;
    case (bus.keycode)
      KEY_UP:    begin heading_d = UP;    moving_d = 1'b1; end
      KEY_DOWN:  begin heading_d = DOWN;  moving_d = 1'b1; end
      KEY_LEFT:  begin heading_d = LEFT;  moving_d = 1'b1; end
      KEY_RIGHT: begin heading_d = RIGHT; moving_d = 1'b1; end
      default:   ;
    endcase
  end

  // A fire edge seen on the tick cycle itself survives the clear and waits for the next tick.
  always_comb begin
    fire_held      = (bus.keycode == KEY_FIRE);
    fire_edge      = fire_held && !fire_prev_q;
    fire_pending_d = bus.frame_tick ? fire_edge : (fire_pending_q || fire_edge);
  end

  // Launch gating uses the cooldown value before this tick's decrement.
  always_comb begin
    launch_ok  = bus.frame_tick && fire_pending_q && (cooldown_q == '0) && (|slot_free);
    cooldown_d = cooldown_q;
    if (bus.frame_tick) begin
      if (launch_ok)              cooldown_d = 8'(FIRE_COOLDOWN);
      else if (cooldown_q != '0)  cooldown_d = cooldown_q - 1'b1;
    end
  end

  always_comb begin
    launch_vec = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (slot_free[i] && !found) begin
        launch_vec[i] = launch_ok;
        found         = 1'b1;
      end
    end
  end

  // The world scrolls opposite to the ship's heading.
  always_comb begin
    scroll_x_d = scroll_x_q;
    scroll_y_d = scroll_y_q;
    if (bus.frame_tick && moving_q) begin
      case (heading_q)
        UP:    scroll_y_d = wrap_step(scroll_y_q, SCROLL_STEP, 1'b1, 11'(SCREEN_H));
        DOWN:  scroll_y_d = wrap_step(scroll_y_q, SCROLL_STEP, 1'b0, 11'(SCREEN_H));
        LEFT:  scroll_x_d = wrap_step(scroll_x_q, SCROLL_STEP, 1'b1, 11'(SCREEN_W));
        RIGHT: scroll_x_d = wrap_step(scroll_x_q, SCROLL_STEP, 1'b0, 11'(SCREEN_W));
      endcase
    end
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .BULLET_SPEED (BULLET_SPEED),
      .BULLET_LIFE  (BULLET_LIFE),
      .BULLET_HALF  (BULLET_HALF),
      .SHIP_X       (SHIP_X),
      .SHIP_Y       (SHIP_Y)
    ) u_slot (
      .sys_clk      (sys_clk),
      .reset_n      (reset_n),
      .launch_i     (launch_vec[i]),
      .frame_tick_i (bus.frame_tick),
      .launch_dir_i (heading_q),
      .draw_x_i     (bus.DrawX),
      .draw_y_i     (bus.DrawY),
      .active_o     (slot_active[i]),
      .free_o       (slot_free[i]),
      .hit_o        (slot_hit[i])
    );
  end

  assign bus.heading      = heading_q;
  assign bus.moving       = moving_q;
  assign bus.scroll_x     = scroll_x_q;
  assign bus.scroll_y     = scroll_y_q;
  assign bus.shoot_bullet = shoot_q;
  assign bus.bullet_on    = bullet_on_q;
  assign bus.fire_ack     = launch_ok;

endmodule

// File: tb/tb_ship_bullet_ctrl.sv
// tb/tb_ship_bullet_ctrl.sv - self-checking bench for ship_bullet_ctrl
module tb_ship_bullet_ctrl;
  import bosconian_pkg::*;

  logic sys_clk = 1'b0;
  logic reset_n;
  always #5 sys_clk = ~sys_clk;

  ship_bullet_ctrl_if bus();

  ship_bullet_ctrl dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string  name;
    integer val;
  } item_t;

  item_t  exp_q[$];
  item_t  got_q[$];
  item_t  e, g;
  int     total = 0;
  int     bad = 0;
  integer last_ack = 0;
  int     ack_count = 0;

  function automatic integer obs(string n);
    case (n)
      "heading":   return integer'(bus.heading);
      "moving":    return integer'(bus.moving);
      "scroll_x":  return integer'(bus.scroll_x);
      "scroll_y":  return integer'(bus.scroll_y);
      "shoot":     return integer'(bus.shoot_bullet);
      "bullet_on": return integer'(bus.bullet_on);
      "fire_ack":  return last_ack;
      "ack_count": return ack_count;
      default:     return -1;
    endcase
  endfunction

  // Push the expected value and record the observed one; comparison happens in each test.
  task automatic want(input string n, input integer v);
    exp_q.push_back('{n, v});
    got_q.push_back('{n, obs(n)});
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic frame();
    bus.frame_tick = 1'b1;
    #1;
    last_ack = integer'(bus.fire_ack);
    if (bus.fire_ack === 1'b1) ack_count++;
    step();
    bus.frame_tick = 1'b0;
    step();
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    bus.keycode    = 8'h00;
    bus.frame_tick = 1'b0;
    bus.DrawX      = 10'd0;
    bus.DrawY      = 10'd0;
    step(2);
    reset_n = 1'b1;
    step();
    ack_count = 0;
  endtask

  task automatic fire_req();
    bus.keycode = KEY_FIRE;
    step();
    bus.keycode = 8'h00;
    step();
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.keycode    = KEY_RIGHT;
    bus.frame_tick = 1'b0;
    bus.DrawX      = 10'd320;
    bus.DrawY      = 10'd240;
    step(2);
    last_ack = integer'(bus.fire_ack);
    want("heading", 0);
    want("moving", 0);
    want("scroll_x", 0);
    want("scroll_y", 0);
    want("shoot", 0);
    want("bullet_on", 0);
    want("fire_ack", 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++;
        $display("FAIL reset.%s: no sample, required %0d", e.name, e.val);
      end else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin
          bad++;
          $display("FAIL reset.%s: got %0d required %0d", e.name, g.val, e.val);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic test_key_scroll();
    do_reset();
    bus.keycode = KEY_RIGHT; step();
    want("heading", 3); want("moving", 1);
    frames(3);
    want("scroll_x", 637); want("scroll_y", 0);
    bus.keycode = 8'h00; step();
    want("moving", 0); want("heading", 3); want("scroll_x", 637);
    frame();
    want("scroll_x", 637);
    bus.keycode = KEY_DOWN; step();
    want("heading", 1);
    frame();
    want("scroll_y", 479);
    bus.keycode = KEY_UP; step();
    want("heading", 0);
    frame();
    want("scroll_y", 0);
    bus.keycode = KEY_LEFT; step();
    frames(2);
    want("heading", 2); want("scroll_x", 639);
    frame();
    want("scroll_x", 0);
    bus.keycode = 8'h55; step();
    want("moving", 0); want("heading", 2);
    bus.keycode = 8'h00;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++;
        $display("FAIL key.%s: no sample, required %0d", e.name, e.val);
      end else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin
          bad++;
          $display("FAIL key.%s: got %0d required %0d", e.name, g.val, e.val);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic test_fire();
    int xs[5]   = '{318, 319, 320, 321, 322};
    int hits[5] = '{0, 1, 1, 1, 0};
    do_reset();
    fire_req();
    frame();
    want("fire_ack", 1);
    bus.DrawX = 10'd320; bus.DrawY = 10'd240; step();
    want("shoot", 1); want("bullet_on", 1);
    for (int i = 0; i < 5; i++) begin
      bus.DrawX = 10'(xs[i]); step();
      want("bullet_on", hits[i]);
    end
    bus.DrawX = 10'd320; bus.DrawY = 10'd241; step(); want("bullet_on", 1);
    bus.DrawY = 10'd242; step(); want("bullet_on", 0);
    bus.DrawY = 10'd238; step(); want("bullet_on", 0);
    frame();
    want("fire_ack", 0);
    frame();
    bus.DrawY = 10'd232; step(); want("bullet_on", 1);
    bus.DrawY = 10'd240; step(); want("bullet_on", 0);
    bus.DrawY = 10'd231; step(); want("bullet_on", 1);
    bus.DrawY = 10'd230; step(); want("bullet_on", 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++;
        $display("FAIL fire.%s: no sample, required %0d", e.name, e.val);
      end else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin
          bad++;
          $display("FAIL fire.%s: got %0d required %0d", e.name, g.val, e.val);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic test_pool();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fire_req();
      frame();
      want("fire_ack", 1);
      frames(8);
    end
    fire_req();
    frame();
    want("fire_ack", 0);
    want("shoot", 1);
    frames(24);
    bus.DrawX = 10'd320; bus.DrawY = 10'd0; step();
    want("bullet_on", 1); want("shoot", 1);
    fire_req();
    frame();
    want("fire_ack", 1);
    bus.DrawY = 10'd240; step(); want("bullet_on", 1);
    bus.DrawY = 10'd0;   step(); want("bullet_on", 0);
    want("ack_count", 5);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++;
        $display("FAIL pool.%s: no sample, required %0d", e.name, e.val);
      end else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin
          bad++;
          $display("FAIL pool.%s: got %0d required %0d", e.name, g.val, e.val);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.keycode = KEY_FIRE; step();
    frames(20);
    want("ack_count", 1);
    bus.keycode = 8'h00; step();
    do_reset();
    fire_req();
    frame();
    want("fire_ack", 1);
    frames(3);
    fire_req();
    frame();
    want("fire_ack", 0);
    frames(7);
    want("ack_count", 1);
    bus.keycode = KEY_FIRE;
    frame();
    want("fire_ack", 0);
    bus.keycode = 8'h00;
    frame();
    want("fire_ack", 1);
    want("ack_count", 2);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++;
        $display("FAIL b2b.%s: no sample, required %0d", e.name, e.val);
      end else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin
          bad++;
          $display("FAIL b2b.%s: got %0d required %0d", e.name, g.val, e.val);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic test_life_reset();
    do_reset();
    bus.keycode = KEY_LEFT; step();
    bus.keycode = 8'h00;    step();
    fire_req();
    frame();
    want("fire_ack", 1);
    frames(63);
    bus.DrawX = 10'd68; bus.DrawY = 10'd240; step();
    want("shoot", 1); want("bullet_on", 1);
    frame();
    want("shoot", 0);
    bus.DrawX = 10'd64; step();
    want("bullet_on", 0);
    fire_req();
    frame();
    want("fire_ack", 1);
    bus.DrawX = 10'd320; bus.DrawY = 10'd240; step();
    want("shoot", 1); want("bullet_on", 1);
    reset_n = 1'b0; step();
    want("shoot", 0); want("bullet_on", 0); want("heading", 0);
    reset_n = 1'b1; step();
    want("shoot", 0); want("bullet_on", 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++;
        $display("FAIL life.%s: no sample, required %0d", e.name, e.val);
      end else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin
          bad++;
          $display("FAIL life.%s: got %0d required %0d", e.name, g.val, e.val);
        end
      end
    end
    got_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_key_scroll();
    test_fire();
    test_pool();
    test_back_to_back();
    test_life_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
